aes_inv_round_ctrl: RTL and testbench
=====================================

// Module: aes_inv_round_ctrl
// PURPOSE
//   Sequences one AES inverse-cipher block through an external combinational inverse-round datapath.
//   - The datapath applies InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns.
//   - This block owns the 128-bit state register, walks round keys NR..0 from the key store,
//     and tells the datapath when the current round is the last one.
//   - Sits between the decrypt input stream and the plaintext output stream, with valid/ready on both sides.
// PARAMETERS
//   NR   10   round count (10/12/14 for AES-128/192/256); rk_idx runs NR..0
//   KIW  4    rk_idx width; must satisfy 2**KIW > NR
// PORTS
//   sys_clk    in   1    single clock, rising edge
//   sys_rst    in   1    synchronous reset, active-high
//   in_data    in   128  ciphertext; byte i = bits [8i+7:8i], column-major (byte 0 = row0/col0)
//   in_valid   in   1    in_data valid
//   in_ready   out  1    block can accept in_data
//   rk_idx     out  KIW  round-key index to key store
//   rk_data    in   128  round key for rk_idx; same cycle (async-read store)
//   dp_state   out  128  state presented to datapath (= state register)
//   dp_key     out  128  rk_data passed through to datapath
//   dp_last    out  1    final round: datapath omits InvMixColumns
//   dp_result  in   128  combinational datapath result for (dp_state, dp_key, dp_last)
//   out_data   out  128  plaintext, held stable while out_valid
//   out_valid  out  1    plaintext valid
//   out_ready  in   1    sink accepts out_data
//   busy       out  1    high in any state other than IDLE
// BEHAVIOUR
//   Reset values: state=0, rk_idx=NR, in_ready=1, out_valid=0, busy=0, dp_last=0, FSM=IDLE.
//   FSM states and transitions:
//   - IDLE: in_ready=1. On in_valid: state<=in_data, rk_idx<=NR, ->ADD.
//   - ADD (1 cycle): state<=state^rk_data, using key NR. Then rk_idx<=NR-1, ->RUN.
//   - RUN: state<=dp_result; dp_last=(rk_idx==0).
//     - If rk_idx!=0: rk_idx<=rk_idx-1, stay in RUN.
//     - If rk_idx==0: ->DONE.
//   - DONE: out_valid=1, out_data=state. On out_ready: ->IDLE and rk_idx<=NR.
//   - out_data is driven by the state register in every state; it is meaningful only while out_valid=1.
//   Latency and throughput:
//   - RUN lasts exactly NR cycles.
//   - out_valid rises NR+2 cycles after the accept edge (12 cycles for NR=10).
//   - in_ready is high only in IDLE; no input buffering.
//   - Minimum block period is NR+3 cycles with out_ready tied high.
//   Boundary conditions:
//   - Outside IDLE, in_valid is ignored and in_data may change freely.
//   - DONE with out_ready low holds out_data and out_valid indefinitely; rk_idx stays 0.
//   - in_valid and out_ready high together in DONE: output retires; input is not taken until the next IDLE cycle.
//   - rk_idx never wraps below 0 and never exceeds NR.
//   - sys_rst in any state: next cycle matches the reset values; a partial block is discarded with no output.
// CONFIGURATION
//   Macro AES_INV_CTRL_ABORT_EN adds port abort (in, 1).
//   - Defined: abort=1 in ADD, RUN or DONE forces the next cycle to IDLE with state=0, rk_idx=NR and out_valid=0.
//     - No output is produced; abort in IDLE has no effect.
//     - abort has priority over out_ready; sys_rst has priority over abort.
//   - Undefined: the port is absent and blocks always run to completion.
// TESTING
//   - FIPS-197 C.1 vector: in=69c4e0d86a7b0430d8cdb78070b4c55a, key store holds the C.1 AES-128 schedule
//     -> out_data=00112233445566778899aabbccddeeff, out_valid at accept+12.
//   - Trace rk_idx during the C.1 run -> sequence 10,9,...,0; dp_last high only in the rk_idx==0 RUN cycle.
//   - Hold out_ready=0 for 20 cycles after out_valid with in_valid=1 and changing in_data
//     -> out_data stable, in_ready=0; output retires when out_ready=1, new block accepted the following cycle.
//   - Back-to-back: in_valid and out_ready tied high, two vectors -> second accept 13 cycles after the first.
//   - Assert sys_rst in RUN with rk_idx=5 -> next cycle FSM=IDLE, in_ready=1, out_valid=0, rk_idx=10;
//     a following block decrypts correctly.
//   - AES_INV_CTRL_ABORT_EN: pulse abort in RUN -> IDLE next cycle, no out_valid.
//     Pulse abort in DONE with out_ready=1 -> no handshake is counted.

Source files
------------

// File: rtl/aes_inv_round_ctrl_if.sv
// Stream, key-store and datapath signals of the AES inverse-round sequencer.
// master = sequencer side, slave = surrounding environment.
interface aes_inv_round_ctrl_if #(
  parameter int unsigned KIW = 4
) ();
  logic [127:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [KIW-1:0] rk_idx;
  logic [127:0]   rk_data;
  logic [127:0]   dp_state;
  logic [127:0]   dp_key;
  logic           dp_last;
  logic [127:0]   dp_result;
  logic [127:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic           busy;

  modport master (
    input  in_data, in_valid, rk_data, dp_result, out_ready,
    output in_ready, rk_idx, dp_state, dp_key, dp_last, out_data, out_valid, busy
  );

  modport slave (
    output in_data, in_valid, rk_data, dp_result, out_ready,
    input  in_ready, rk_idx, dp_state, dp_key, dp_last, out_data, out_valid, busy
  );
endinterface

// File: rtl/aes_inv_round_ctrl.sv
// AES inverse-cipher block sequencer: owns the state register, walks round keys NR..0 through
// an external inverse-round datapath. Define AES_INV_CTRL_ABORT_EN to add the abort input.
module aes_inv_round_ctrl #(
  parameter int unsigned NR  = 10,
  parameter int unsigned KIW = 4
) (
  input logic                  sys_clk,
  input logic                  sys_rst,
`ifdef AES_INV_CTRL_ABORT_EN
  input logic                  abort,
`endif
  aes_inv_round_ctrl_if.master ctrl
);

  localparam logic [KIW-1:0] RkTop  = KIW'(NR);
  localparam logic [KIW-1:0] RkNext = KIW'(NR - 1);
  localparam logic [KIW-1:0] RkOne  = KIW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StRun,
    StDone
  } fsm_e;

  fsm_e           fsm_q, fsm_d;
  logic [127:0]   state_q, state_d;
  logic [KIW-1:0] rk_idx_q, rk_idx_d;
  logic           abort_req;

`ifdef AES_INV_CTRL_ABORT_EN
  assign abort_req = abort & (fsm_q != StIdle);
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    rk_idx_d = rk_idx_q;
    unique case (fsm_q)
      StIdle: begin
        if (ctrl.in_valid) begin
          state_d  = ctrl.in_data;
          rk_idx_d = RkTop;
          fsm_d    = StAdd;
        end
      end
      StAdd: begin
        // Initial whitening with the last round key; the datapath is bypassed here.
        state_d  = state_q ^ ctrl.rk_data;
        rk_idx_d = RkNext;
        fsm_d    = StRun;
      end
      StRun: begin
        state_d = ctrl.dp_result;
        if (rk_idx_q != '0) begin
          rk_idx_d = rk_idx_q - RkOne;
        end else begin
          fsm_d = StDone;
        end
      end
      StDone: begin
        if (ctrl.out_ready) begin
          rk_idx_d = RkTop;
          fsm_d    = StIdle;
        end
      end
    endcase

    if (abort_req) begin
      fsm_d    = StIdle;
      state_d  = '0;
      rk_idx_d = RkTop;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      fsm_q    <= StIdle;
      state_q  <= '0;
      rk_idx_q <= RkTop;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      rk_idx_q <= rk_idx_d;
    end
  end

  assign ctrl.in_ready  = (fsm_q == StIdle);
  assign ctrl.rk_idx    = rk_idx_q;
  assign ctrl.dp_state  = state_q;
  assign ctrl.dp_key    = ctrl.rk_data;
  assign ctrl.dp_last   = (fsm_q == StRun) && (rk_idx_q == '0);
  assign ctrl.out_data  = state_q;
  // An abort in DONE suppresses the handshake in the same cycle.
  assign ctrl.out_valid = (fsm_q == StDone) && !abort_req;
  assign ctrl.busy      = (fsm_q != StIdle);

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: models the inverse-round datapath and key store, and checks
// results against a whole-block FIPS-197 inverse cipher and the C.1 known-answer vector.
module tb_aes_inv_round_ctrl;

  localparam int unsigned NR  = 10;
  localparam int unsigned KIW = 4;

  logic sys_clk = 1'b0;
  logic sys_rst;
`ifdef AES_INV_CTRL_ABORT_EN
  logic abort;
`endif

  aes_inv_round_ctrl_if #(.KIW(KIW)) bus ();

  aes_inv_round_ctrl #(
    .NR (NR),
    .KIW(KIW)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
`ifdef AES_INV_CTRL_ABORT_EN
    .abort  (abort),
`endif
    .ctrl   (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]   sbox     [256];
  logic [7:0]   inv_sbox [256];
  logic [127:0] rk       [16];

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] w;
    w = {v, v} << n;
    return w[15:8];
  endfunction

  task automatic init_tables();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++) if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
      sbox[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    for (int a = 0; a < 256; a++) inv_sbox[sbox[a]] = 8'(a);
  endtask

  // One inverse round on the column-major bus layout: byte 4*col+row.
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   a [16];
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        a[4*c+w] = inv_sbox[s[8*(4*((c-w+4)%4)+w) +: 8]] ^ k[8*(4*c+w) +: 8];
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        if (last) r[8*(4*c+w) +: 8] = a[4*c+w];
        else r[8*(4*c+w) +: 8] = gmul(a[4*c+w], 8'h0e) ^ gmul(a[4*c+(w+1)%4], 8'h0b) ^
                                 gmul(a[4*c+(w+2)%4], 8'h0d) ^ gmul(a[4*c+(w+3)%4], 8'h09);
    return r;
  endfunction

  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk[NR];
    for (int r = int'(NR) - 1; r >= 0; r--) s = inv_round(s, rk[r], r == 0);
    return s;
  endfunction

  function automatic logic [127:0] fips2bus(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15-i) +: 8];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic load_c1_keys();
    logic [7:0] kb [176];
    logic [7:0] t  [4];
    logic [7:0] tmp;
    logic [7:0] rcon;
    rcon = 8'h01;
    for (int i = 0; i < 16; i++) kb[i] = 8'(i);
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) t[j] = kb[4*(i-1)+j];
      if (i % 4 == 0) begin
        tmp  = t[0];
        t[0] = sbox[t[1]] ^ rcon;
        t[1] = sbox[t[2]];
        t[2] = sbox[t[3]];
        t[3] = sbox[tmp];
        rcon = xtime(rcon);
      end
      for (int j = 0; j < 4; j++) kb[4*i+j] = kb[4*(i-4)+j] ^ t[j];
    end
    for (int r = 0; r < 16; r++)
      for (int b = 0; b < 16; b++) rk[r][8*b +: 8] = (r <= int'(NR)) ? kb[16*r+b] : 8'h00;
  endtask

  // ---------------- environment: key store and datapath ----------------
  assign bus.rk_data   = rk[bus.rk_idx];
  assign bus.dp_result = inv_round(bus.dp_state, bus.dp_key, bus.dp_last);

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Presents one block, waits for the result, stalls the sink, then retires it.
  // lat counts cycles from the accepting cycle to the first out_valid cycle.
  task automatic drive_block(input logic [127:0] ct, input int stall,
                             output logic [127:0] got, output int lat);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 40) begin
      tick();
      guard++;
    end
    bus.in_data  = ct;
    bus.in_valid = 1'b1;
    tick();
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = rand128();
      tick();
      lat++;
    end
    repeat (stall) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      tick();
    end
    got           = bus.out_data;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) tick();
    sys_rst = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1)
      begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0)
      begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.busy !== 1'b0)
      begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.dp_last !== 1'b0)
      begin n_err++; $display("FAIL reset_dp_last got %b want 0", bus.dp_last); end
    n_cmp++; if (bus.rk_idx !== KIW'(NR))
      begin n_err++; $display("FAIL reset_rk_idx got %0d want %0d", bus.rk_idx, NR); end
    n_cmp++; if (bus.dp_state !== 128'h0)
      begin n_err++; $display("FAIL reset_state got %h want 0", bus.dp_state); end
    n_cmp++; if (bus.dp_key !== rk[NR])
      begin n_err++; $display("FAIL reset_dp_key got %h want %h", bus.dp_key, rk[NR]); end
  endtask

  task automatic test_c1();
    logic [127:0]   ct;
    logic [127:0]   exp;
    logic [KIW-1:0] exp_idx;
    load_c1_keys();
    ct  = fips2bus(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    exp = fips2bus(128'h00112233445566778899aabbccddeeff);
    bus.in_data  = ct;
    bus.in_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      bus.in_valid = 1'b0;
      bus.in_data  = rand128();
      exp_idx = (k == 1) ? KIW'(NR) : ((k <= int'(NR) + 1) ? KIW'(int'(NR) + 1 - k) : '0);
      n_cmp++; if (bus.rk_idx !== exp_idx)
        begin n_err++; $display("FAIL c1_rk_idx cyc %0d got %0d want %0d", k, bus.rk_idx, exp_idx); end
      n_cmp++; if (bus.dp_last !== 1'(k == int'(NR) + 1))
        begin n_err++; $display("FAIL c1_dp_last cyc %0d got %b", k, bus.dp_last); end
      n_cmp++; if (bus.out_valid !== 1'(k == int'(NR) + 2))
        begin n_err++; $display("FAIL c1_out_valid cyc %0d got %b", k, bus.out_valid); end
    end
    n_cmp++; if (bus.out_data !== exp)
      begin n_err++; $display("FAIL c1_plaintext got %h want %h", bus.out_data, exp); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      begin n_err++; $display("FAIL c1_retire got ov=%b ir=%b want ov=0 ir=1",
                              bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_backpressure();
    logic [127:0] ct, ct2, exp, exp2;
    int guard;
    ct   = rand128();
    exp  = ref_decrypt(ct);
    ct2  = rand128();
    exp2 = ref_decrypt(ct2);
    bus.in_data  = ct;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 40) begin tick(); guard++; end
    bus.in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.in_data = rand128();
      #1;
      n_cmp++; if (bus.out_data !== exp || bus.out_valid !== 1'b1)
        begin n_err++; $display("FAIL hold_out cyc %0d got %h/%b want %h/1",
                                k, bus.out_data, bus.out_valid, exp); end
      n_cmp++; if (bus.in_ready !== 1'b0 || bus.rk_idx !== '0)
        begin n_err++; $display("FAIL hold_ctrl cyc %0d got ir=%b idx=%0d want ir=0 idx=0",
                                k, bus.in_ready, bus.rk_idx); end
      tick();
    end
    bus.in_data   = ct2;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
      begin n_err++; $display("FAIL hold_retire got ir=%b ov=%b busy=%b want 1/0/0",
                              bus.in_ready, bus.out_valid, bus.busy); end
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0)
      begin n_err++; $display("FAIL hold_next_accept got busy=%b ir=%b want 1/0",
                              bus.busy, bus.in_ready); end
    guard = 0;
    while (!bus.out_valid && guard < 40) begin tick(); guard++; end
    n_cmp++; if (bus.out_data !== exp2 || bus.out_valid !== 1'b1)
      begin n_err++; $display("FAIL hold_second got %h want %h", bus.out_data, exp2); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [127:0] ct  [2];
    logic [127:0] exp [$];
    int           acc [$];
    int           outc[$];
    int           ni, no, cyc;
    ni = 0; no = 0; cyc = 0;
    ct[0] = rand128();
    ct[1] = rand128();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = ct[0];
    while (no < 2 && cyc < 60) begin
      if (bus.in_valid && bus.in_ready) begin
        acc.push_back(cyc);
        exp.push_back(ref_decrypt(ct[ni]));
        ni++;
      end
      if (bus.out_valid) begin
        outc.push_back(cyc);
        n_cmp++;
        if (exp.size() == 0) begin
          n_err++; $display("FAIL b2b_spurious_out cyc %0d got %h", cyc, bus.out_data);
        end else if (bus.out_data !== exp[0]) begin
          n_err++; $display("FAIL b2b_data got %h want %h", bus.out_data, exp[0]);
        end
        if (exp.size() != 0) void'(exp.pop_front());
        no++;
      end
      tick();
      cyc++;
      if (ni == 1) bus.in_data = ct[1];
      else if (ni >= 2) bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    n_cmp++; if (acc.size() != 2 || outc.size() != 2)
      begin n_err++; $display("FAIL b2b_count got acc=%0d out=%0d want 2/2",
                              acc.size(), outc.size()); end
    else begin
      n_cmp++; if (acc[1] - acc[0] != int'(NR) + 3)
        begin n_err++; $display("FAIL b2b_period got %0d want %0d", acc[1] - acc[0], NR + 3); end
      for (int i = 0; i < 2; i++) begin
        n_cmp++; if (outc[i] - acc[i] != int'(NR) + 2)
          begin n_err++; $display("FAIL b2b_latency blk %0d got %0d want %0d",
                                  i, outc[i] - acc[i], NR + 2); end
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] ct, exp, got;
    int lat;
    for (int b = 0; b < 8; b++) begin
      for (int r = 0; r <= int'(NR); r++) rk[r] = rand128();
      ct  = rand128();
      exp = ref_decrypt(ct);
      repeat ($urandom_range(0, 3)) tick();
      drive_block(ct, $urandom_range(0, 5), got, lat);
      n_cmp++; if (got !== exp)
        begin n_err++; $display("FAIL rand_data blk %0d got %h want %h", b, got, exp); end
      n_cmp++; if (lat != int'(NR) + 2)
        begin n_err++; $display("FAIL rand_latency blk %0d got %0d want %0d", b, lat, NR + 2); end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] ct, got;
    int guard, lat;
    bit seen;
    bus.in_data  = rand128();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    guard = 0;
    while (!(bus.busy && bus.rk_idx == KIW'(5)) && guard < 30) begin tick(); guard++; end
    n_cmp++; if (bus.rk_idx !== KIW'(5) || bus.busy !== 1'b1)
      begin n_err++; $display("FAIL rst_reach got idx=%0d busy=%b want 5/1",
                              bus.rk_idx, bus.busy); end
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
      begin n_err++; $display("FAIL rst_flags got ir=%b ov=%b busy=%b want 1/0/0",
                              bus.in_ready, bus.out_valid, bus.busy); end
    n_cmp++; if (bus.rk_idx !== KIW'(NR) || bus.dp_state !== 128'h0 || bus.dp_last !== 1'b0)
      begin n_err++; $display("FAIL rst_state got idx=%0d st=%h last=%b want %0d/0/0",
                              bus.rk_idx, bus.dp_state, bus.dp_last, NR); end
    seen = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    n_cmp++; if (seen !== 1'b0)
      begin n_err++; $display("FAIL rst_no_output got out_valid seen want none"); end
    load_c1_keys();
    ct = fips2bus(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    drive_block(ct, 2, got, lat);
    n_cmp++; if (got !== fips2bus(128'h00112233445566778899aabbccddeeff))
      begin n_err++; $display("FAIL rst_after_block got %h", got); end
    n_cmp++; if (lat != int'(NR) + 2)
      begin n_err++; $display("FAIL rst_after_latency got %0d want %0d", lat, NR + 2); end
  endtask

`ifdef AES_INV_CTRL_ABORT_EN
  task automatic test_abort();
    logic [127:0] ct, got;
    int guard, lat;
    bit seen;
    bus.in_data  = rand128();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    guard = 0;
    while (!(bus.busy && bus.rk_idx == KIW'(6)) && guard < 30) begin tick(); guard++; end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.rk_idx !== KIW'(NR) ||
                 bus.dp_state !== 128'h0)
      begin n_err++; $display("FAIL abort_run got ir=%b ov=%b idx=%0d st=%h",
                              bus.in_ready, bus.out_valid, bus.rk_idx, bus.dp_state); end
    seen = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    n_cmp++; if (seen !== 1'b0)
      begin n_err++; $display("FAIL abort_run_output got out_valid seen want none"); end
    bus.in_data  = rand128();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 40) begin tick(); guard++; end
    bus.out_ready = 1'b1;
    abort         = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0)
      begin n_err++; $display("FAIL abort_done_handshake got out_valid=%b want 0", bus.out_valid); end
    tick();
    abort         = 1'b0;
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1 || bus.dp_state !== 128'h0)
      begin n_err++; $display("FAIL abort_done_idle got ir=%b st=%h", bus.in_ready, bus.dp_state); end
    ct = rand128();
    drive_block(ct, 1, got, lat);
    n_cmp++; if (got !== ref_decrypt(ct))
      begin n_err++; $display("FAIL abort_after_block got %h want %h", got, ref_decrypt(ct)); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog_timeout compared=%0d", n_cmp);
    $fatal(1, "bench timed out");
  end

  initial begin
    sys_rst       = 1'b1;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
`ifdef AES_INV_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    init_tables();
    load_c1_keys();
    test_reset();
    test_c1();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef AES_INV_CTRL_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
